// File: rtl/filter_menu_ctrl.sv
// Sequencing controller for the six-box filter menu: button edges drive a wrapping cursor,
// the arrow sprite follows at frame boundaries, and confirm hands a filter to the pipeline.
module filter_menu_ctrl #(
    parameter int NUM_FILTERS    = 6,
    parameter int V_ACTIVE       = 768,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        confirm_in,
    input  logic        back_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        apply_done_in,
    output logic [2:0]  select_out,
    output logic [10:0] arrow_x_out,
    output logic [9:0]  arrow_y_out,
    output logic        use_up_arrow_out,
    output logic        apply_start_out,
    output logic [2:0]  active_filter_out,
    output logic        active_valid_out,
    output logic [1:0]  state_out,
    output logic        error_out
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_SEL = 3'(NUM_FILTERS - 1);
    localparam logic [9:0]       V_TICK   = 10'(V_ACTIVE);
    localparam logic [9:0]       ARROW_Y  = 10'd334;

    typedef enum logic [1:0] {
        ST_MENU       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_APPLY      = 2'd2,
        ST_SHOW       = 2'd3
    } state_t;

    // Boxes are laid out three per row; the arrow column repeats for the second row.
    function automatic logic [10:0] arrow_x_of(input logic [2:0] sel);
        case (sel)
            3'd0, 3'd3: arrow_x_of = 11'd120;
            3'd1, 3'd4: arrow_x_of = 11'd460;
            3'd2, 3'd5: arrow_x_of = 11'd800;
            default:    arrow_x_of = 11'd120;
        endcase
    endfunction

    logic             left_prev_r;
    logic             right_prev_r;
    logic             confirm_prev_r;
    logic             back_prev_r;
    logic             left_edge_s;
    logic             right_edge_s;
    logic             confirm_edge_s;
    logic             back_edge_s;
    logic             frame_tick_s;
    logic [2:0]       sel_next_s;
    logic [2:0]       select_r;
    logic [10:0]      arrow_x_r;
    logic [9:0]       arrow_y_r;
    logic             use_up_arrow_r;
    logic             apply_start_r;
    logic [2:0]       active_filter_r;
    logic             active_valid_r;
    logic             error_r;
    state_t           state_r;
    logic [CNT_W-1:0] timeout_cnt_r;

    // Button history; resets high so a button held through reset yields no edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            left_prev_r    <= 1'b1;
            right_prev_r   <= 1'b1;
            confirm_prev_r <= 1'b1;
            back_prev_r    <= 1'b1;
        end else begin
            left_prev_r    <= left_in;
            right_prev_r   <= right_in;
            confirm_prev_r <= confirm_in;
            back_prev_r    <= back_in;
        end
    end

    // Rising-edge detection and the frame boundary strobe.
    always_comb begin
        left_edge_s    = left_in & ~left_prev_r;
        right_edge_s   = right_in & ~right_prev_r;
        confirm_edge_s = confirm_in & ~confirm_prev_r;
        back_edge_s    = back_in & ~back_prev_r;
        frame_tick_s   = (hcount_in == 11'd0) && (vcount_in == V_TICK);
    end

    // Wrapping cursor step; simultaneous left and right cancel out.
    always_comb begin
        sel_next_s = select_r;
        if ((state_r == ST_MENU) && (left_edge_s ^ right_edge_s)) begin
            if (right_edge_s) begin
                sel_next_s = (select_r == LAST_SEL) ? 3'd0 : select_r + 3'd1;
            end else begin
                sel_next_s = (select_r == 3'd0) ? LAST_SEL : select_r - 3'd1;
            end
        end else begin
            sel_next_s = select_r;
        end
    end

    // Cursor register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            select_r <= 3'd0;
        end else begin
            select_r <= sel_next_s;
        end
    end

    // Arrow placement only moves at the frame tick so the sprite never tears.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            arrow_x_r      <= 11'd120;
            arrow_y_r      <= ARROW_Y;
            use_up_arrow_r <= 1'b1;
        end else if (frame_tick_s) begin
            arrow_x_r      <= arrow_x_of(select_r);
            arrow_y_r      <= ARROW_Y;
            use_up_arrow_r <= (select_r < 3'd3);
        end
    end

    // Menu/apply sequencer with start pulse, done handshake and saturating timeout.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r         <= ST_MENU;
            apply_start_r   <= 1'b0;
            active_filter_r <= 3'd0;
            active_valid_r  <= 1'b0;
            error_r         <= 1'b0;
            timeout_cnt_r   <= '0;
        end else begin
            apply_start_r <= 1'b0;
            case (state_r)
                ST_MENU: begin
                    if (confirm_edge_s) begin
                        state_r         <= ST_WAIT_FRAME;
                        active_filter_r <= select_r;
                        error_r         <= 1'b0;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (back_edge_s) begin
                        state_r <= ST_MENU;
                    end else if (frame_tick_s) begin
                        state_r       <= ST_APPLY;
                        apply_start_r <= 1'b1;
                        timeout_cnt_r <= '0;
                    end
                end
                ST_APPLY: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (apply_done_in) begin
                        state_r        <= ST_SHOW;
                        active_valid_r <= 1'b1;
                    end else if (timeout_cnt_r == CNT_LAST) begin
                        state_r <= ST_MENU;
                        error_r <= 1'b1;
                    end else if (timeout_cnt_r != CNT_MAX) begin
                        timeout_cnt_r <= timeout_cnt_r + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (back_edge_s) begin
                        state_r        <= ST_MENU;
                        active_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_MENU;
                end
            endcase
        end
    end

    assign select_out        = select_r;
    assign arrow_x_out       = arrow_x_r;
    assign arrow_y_out       = arrow_y_r;
    assign use_up_arrow_out  = use_up_arrow_r;
    assign apply_start_out   = apply_start_r;
    assign active_filter_out = active_filter_r;
    assign active_valid_out  = active_valid_r;
    assign state_out         = state_r;
    assign error_out         = error_r;

endmodule

// File: tb/tb_filter_menu_ctrl.sv
// Scoreboard bench for filter_menu_ctrl: a cycle-level reference model pushes expected
// output snapshots and start events; an independent monitor pops and compares them.
module tb_filter_menu_ctrl;

    localparam int TO = 100;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        left_in, right_in, confirm_in, back_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        apply_done_in;
    logic [2:0]  select_out;
    logic [10:0] arrow_x_out;
    logic [9:0]  arrow_y_out;
    logic        use_up_arrow_out;
    logic        apply_start_out;
    logic [2:0]  active_filter_out;
    logic        active_valid_out;
    logic [1:0]  state_out;
    logic        error_out;

    typedef struct packed {
        logic [2:0]  sel;
        logic [10:0] ax;
        logic [9:0]  ay;
        logic        up;
        logic        start;
        logic [2:0]  af;
        logic        valid;
        logic [1:0]  st;
        logic        err;
    } snap_t;

    snap_t exp_q[$];
    int    start_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model state (phase: 0 menu, 1 waiting for frame, 2 applying, 3 showing)
    int m_sel, m_ax, m_ay, m_up, m_start, m_af, m_valid, m_phase, m_err, m_napply;
    bit m_prev[4];
    int x_tab[3] = '{120, 460, 800};

    filter_menu_ctrl #(.NUM_FILTERS(6), .V_ACTIVE(768), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .left_in(left_in), .right_in(right_in), .confirm_in(confirm_in), .back_in(back_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .apply_done_in(apply_done_in),
        .select_out(select_out), .arrow_x_out(arrow_x_out), .arrow_y_out(arrow_y_out),
        .use_up_arrow_out(use_up_arrow_out), .apply_start_out(apply_start_out),
        .active_filter_out(active_filter_out), .active_valid_out(active_valid_out),
        .state_out(state_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic snap_t act_snap();
        snap_t s;
        s.sel = select_out; s.ax = arrow_x_out; s.ay = arrow_y_out; s.up = use_up_arrow_out;
        s.start = apply_start_out; s.af = active_filter_out; s.valid = active_valid_out;
        s.st = state_out; s.err = error_out;
        return s;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_ax = 120; m_ay = 334; m_up = 1; m_start = 0; m_af = 0;
        m_valid = 0; m_phase = 0; m_err = 0; m_napply = 0;
        for (int i = 0; i < 4; i++) m_prev[i] = 1'b1;
    endtask

    task automatic model_step();
        bit btn[4];
        bit e[4];
        bit tick;
        int old_sel;
        int n;
        if (!rst_n_in) begin
            model_reset();
            return;
        end
        btn = '{left_in, right_in, confirm_in, back_in};
        for (int i = 0; i < 4; i++) begin
            e[i] = btn[i] && !m_prev[i];
            m_prev[i] = btn[i];
        end
        tick = (hcount_in == 11'd0) && (vcount_in == 10'd768);
        old_sel = m_sel;
        m_start = 0;
        if (tick) begin
            m_ax = x_tab[old_sel % 3];
            m_ay = 334;
            m_up = (old_sel < 3) ? 1 : 0;
        end
        case (m_phase)
            0: begin
                if (e[1] && !e[0]) m_sel = (old_sel + 1) % 6;
                else if (e[0] && !e[1]) m_sel = (old_sel + 5) % 6;
                if (e[2]) begin m_phase = 1; m_af = old_sel; m_err = 0; end
            end
            1: begin
                if (e[3]) m_phase = 0;
                else if (tick) begin
                    m_phase = 2; m_start = 1; m_napply = 0;
                    start_q.push_back(m_af);
                end
            end
            2: begin
                n = m_napply + 1;
                if (apply_done_in) begin m_phase = 3; m_valid = 1; end
                else if (n == TO) begin m_phase = 0; m_err = 1; end
                else m_napply = n;
            end
            default: begin
                if (e[3]) begin m_phase = 0; m_valid = 0; end
            end
        endcase
    endtask

    // One clock: the model consumes the inputs seen at the edge and queues its expectation.
    task automatic step();
        snap_t s;
        @(posedge clk_in);
        model_step();
        s.sel = 3'(m_sel); s.ax = 11'(m_ax); s.ay = 10'(m_ay); s.up = 1'(m_up);
        s.start = 1'(m_start); s.af = 3'(m_af); s.valid = 1'(m_valid);
        s.st = 2'(m_phase); s.err = 1'(m_err);
        exp_q.push_back(s);
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: left_in = v;
            1: right_in = v;
            2: confirm_in = v;
            default: back_in = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1); step();
        set_btn(idx, 1'b0); step();
    endtask

    task automatic tick();
        hcount_in = 11'd0; vcount_in = 10'd768; step();
        hcount_in = 11'd5; vcount_in = 10'd200;
    endtask

    task automatic check_reset(input string name);
        snap_t r;
        snap_t a;
        r = '{sel: 3'd0, ax: 11'd120, ay: 10'd334, up: 1'b1, start: 1'b0, af: 3'd0,
              valid: 1'b0, st: 2'd0, err: 1'b0};
        a = act_snap();
        total++;
        if (a !== r) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, a, r);
        end
    endtask

    // Monitor: compares every presented output snapshot and every start pulse.
    initial begin
        snap_t e;
        snap_t a;
        int    f;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = act_snap();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL snapshot t=%0t got sel=%0d x=%0d y=%0d up=%0b st=%0b af=%0d v=%0b state=%0d err=%0b want sel=%0d x=%0d y=%0d up=%0b st=%0b af=%0d v=%0b state=%0d err=%0b",
                             $time, a.sel, a.ax, a.ay, a.up, a.start, a.af, a.valid, a.st, a.err,
                             e.sel, e.ax, e.ay, e.up, e.start, e.af, e.valid, e.st, e.err);
                end
            end
            if (apply_start_out === 1'b1) begin
                total++;
                if (start_q.size() == 0) begin
                    bad++;
                    $display("FAIL start_pulse t=%0t got unexpected start filter=%0d want none", $time, active_filter_out);
                end else begin
                    f = start_q.pop_front();
                    if (active_filter_out !== 3'(f)) begin
                        bad++;
                        $display("FAIL start_filter t=%0t got=%0d want=%0d", $time, active_filter_out, f);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        rst_n_in = 1'b0;
        left_in = 1'b0; right_in = 1'b0; confirm_in = 1'b0; back_in = 1'b0;
        hcount_in = 11'd5; vcount_in = 10'd200; apply_done_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_reset("reset_initial");
        rst_n_in = 1'b1;
        idle(3);

        repeat (3) press(1);
        tick();
        repeat (3) press(1);
        tick();

        press(0);
        left_in = 1'b1; right_in = 1'b1; step();
        left_in = 1'b0; right_in = 1'b0; step();
        right_in = 1'b1; idle(100);
        right_in = 1'b0; step();

        press(1);
        idle(5);
        tick();
        idle(2);

        for (int k = 0; k < 6 && m_sel != 4; k++) press(1);
        press(2);
        idle(5);
        tick();
        idle(50);
        apply_done_in = 1'b1; step();
        apply_done_in = 1'b0; idle(3);
        press(3);
        idle(2);

        press(2);
        tick();
        idle(TO + 10);
        press(2);
        press(3);
        idle(2);

        press(2);
        tick();
        idle(10);
        rst_n_in = 1'b0;
        confirm_in = 1'b1;
        #1;
        check_reset("reset_mid_apply");
        idle(2);
        rst_n_in = 1'b1;
        idle(5);
        confirm_in = 1'b0;
        idle(2);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) left_in = ~left_in;
            if ($urandom_range(0, 9) == 0) right_in = ~right_in;
            if ($urandom_range(0, 14) == 0) confirm_in = ~confirm_in;
            if ($urandom_range(0, 24) == 0) back_in = ~back_in;
            if ($urandom_range(0, 24) == 0) begin
                hcount_in = 11'd0; vcount_in = 10'd768;
            end else begin
                hcount_in = 11'($urandom_range(0, 1343));
                vcount_in = 10'($urandom_range(0, 805));
            end
            apply_done_in = ($urandom_range(0, 19) == 0);
            step();
        end
        left_in = 1'b0; right_in = 1'b0; confirm_in = 1'b0; back_in = 1'b0; apply_done_in = 1'b0;
        hcount_in = 11'd5; vcount_in = 10'd200;
        idle(3);

        total++;
        if (exp_q.size() != 0 || start_q.size() != 0) begin
            bad++;
            $display("FAIL queues_drained got snapshots=%0d starts=%0d want 0 and 0", exp_q.size(), start_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
